sprite_palette_ram: RTL and testbench

// - Writable, multi-palette successor to the fixed per-sprite combinational colour tables.
// - Holds NUM_PAL palettes of 2**IDX_W 24-bit RGB entries, loaded at run time by the sprite loader.
// - Registered 2-cycle lookup sits between the sprite ROM index output and the VGA colour mux.
// - Adds a transparency flag and a frame-counted "hit flash" (solid white) per palette.
//

---
 rtl/sprite_palette_if.sv | 45 ++++
 rtl/sprite_palette_ram.sv | 168 ++++++++++++++++
 tb/tb_sprite_palette_ram.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_palette_if.sv
// Sprite palette bus: run-time palette loading, pixel lookup, per-palette hit flash.
// The master is the sprite pipeline and loader; the slave is the palette RAM.
interface sprite_palette_if #(
    parameter int IDX_W   = 3,
    parameter int NUM_PAL = 4
);
    localparam int PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;

    logic             wr_en;
    logic [PAL_W-1:0] wr_pal;
    logic [IDX_W-1:0] wr_idx;
    logic [23:0]      wr_rgb;
    logic             init_busy;

    logic             pix_valid_in;
    logic [PAL_W-1:0] pix_pal;
    logic [IDX_W-1:0] pix_idx;

    logic             frame_start;
    logic             flash_req;
    logic [PAL_W-1:0] flash_pal;

    logic [7:0]       Red;
    logic [7:0]       Green;
    logic [7:0]       Blue;
    logic             pix_valid_out;
    logic             transparent_out;
    logic             flash_active;

    modport master (
        output wr_en, wr_pal, wr_idx, wr_rgb,
        output pix_valid_in, pix_pal, pix_idx,
        output frame_start, flash_req, flash_pal,
        input  init_busy, Red, Green, Blue,
        input  pix_valid_out, transparent_out, flash_active
    );

    modport slave (
        input  wr_en, wr_pal, wr_idx, wr_rgb,
        input  pix_valid_in, pix_pal, pix_idx,
        input  frame_start, flash_req, flash_pal,
        output init_busy, Red, Green, Blue,
        output pix_valid_out, transparent_out, flash_active
    );
endinterface

// File: rtl/sprite_palette_ram.sv
// Multi-palette RGB lookup RAM with a zeroing sweep after reset, a 2-cycle
// read-first lookup pipeline, a transparency flag and a frame-counted white flash.
module sprite_palette_ram #(
    parameter int IDX_W           = 3,
    parameter int NUM_PAL         = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FLASH_FRAMES    = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    sprite_palette_if.slave   bus
);
    localparam int PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
    localparam int AW    = PAL_W + IDX_W;
    localparam int DEPTH = NUM_PAL * (2 ** IDX_W);

    localparam logic [AW-1:0]    LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [PAL_W:0]   PAL_LIMIT  = (PAL_W + 1)'(NUM_PAL);
    localparam logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(TRANSPARENT_IDX);
    localparam logic [7:0]       FLASH_LOAD = 8'(FLASH_FRAMES);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   sweep_addr;
    logic [AW-1:0]   sweep_nxt;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [23:0]     mem_wdata;
    logic [23:0]     mem [DEPTH];

    logic            wr_pal_ok;
    logic            rd_pal_ok;
    logic [AW-1:0]   rd_addr;
    logic            in_init;

    logic            flash_on;
    logic [PAL_W-1:0] flash_pal_q;
    logic [7:0]      flash_cnt;

    logic            s1_valid;
    logic            s1_transp;
    logic            s1_flash;
    logic            s1_zero;
    logic [23:0]     s1_rdata;

    logic [23:0]     rgb_q;
    logic            valid_q;
    logic            transp_q;

    // Palette numbers past NUM_PAL exist in the address space only when NUM_PAL is not a power of two.
    assign wr_pal_ok = ({1'b0, bus.wr_pal} < PAL_LIMIT);
    assign rd_pal_ok = ({1'b0, bus.pix_pal} < PAL_LIMIT);
    assign rd_addr   = {bus.pix_pal, bus.pix_idx};
    assign in_init   = (state == ST_INIT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
        end else begin
            state      <= state_nxt;
            sweep_addr <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_addr;
        mem_we    = 1'b0;
        mem_waddr = sweep_addr;
        mem_wdata = '0;
        case (state)
            ST_INIT: begin
                mem_we = !Reset;
                if (sweep_addr == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                    sweep_nxt = '0;
                end else begin
                    sweep_nxt = sweep_addr + AW'(1);
                end
            end
            ST_RUN: begin
                if (bus.wr_en && wr_pal_ok && !Reset) begin
                    mem_we    = 1'b1;
                    mem_waddr = {bus.wr_pal, bus.wr_idx};
                    mem_wdata = bus.wr_rgb;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // A request in the same cycle as a flash_req or the final frame_start still sees the old flash state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flash_on    <= 1'b0;
            flash_pal_q <= '0;
            flash_cnt   <= '0;
        end else if (bus.flash_req) begin
            flash_on    <= 1'b1;
            flash_pal_q <= bus.flash_pal;
            flash_cnt   <= FLASH_LOAD;
        end else if (bus.frame_start && flash_on) begin
            flash_cnt <= flash_cnt - 8'd1;
            if (flash_cnt == 8'd1) begin
                flash_on <= 1'b0;
            end
        end
    end

    // Reading the array here, alongside the write port, is what makes a same-address collision read-first.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid  <= 1'b0;
            s1_transp <= 1'b0;
            s1_flash  <= 1'b0;
            s1_zero   <= 1'b0;
            s1_rdata  <= '0;
        end else begin
            s1_valid  <= bus.pix_valid_in;
            s1_zero   <= in_init || !rd_pal_ok;
            s1_transp <= in_init || (rd_pal_ok && (bus.pix_idx == TRANSP_IDX));
            s1_flash  <= flash_on && rd_pal_ok && (bus.pix_pal == flash_pal_q)
                         && (bus.pix_idx != TRANSP_IDX);
            s1_rdata  <= rd_pal_ok ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q  <= 1'b0;
            transp_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            valid_q <= s1_valid;
            if (s1_valid) begin
                transp_q <= s1_transp;
                if (s1_zero) begin
                    rgb_q <= '0;
                end else if (s1_flash) begin
                    rgb_q <= 24'hFFFFFF;
                end else begin
                    rgb_q <= s1_rdata;
                end
            end
        end
    end

    assign bus.init_busy       = in_init;
    assign bus.flash_active    = flash_on;
    assign bus.pix_valid_out   = valid_q;
    assign bus.transparent_out = transp_q;
    assign bus.Red             = rgb_q[23:16];
    assign bus.Green           = rgb_q[15:8];
    assign bus.Blue            = rgb_q[7:0];
endmodule

// File: tb/tb_sprite_palette_ram.sv
// Directed bench for sprite_palette_ram: init sweep, lookups, collisions, flash timing
// and reset during the sweep, each against hand-computed values.
module tb_sprite_palette_ram;
    logic Clk;
    logic Reset;
    int   compared;
    int   mismatched;

    sprite_palette_if #(.IDX_W(3), .NUM_PAL(4)) bus ();

    sprite_palette_ram #(
        .IDX_W(3), .NUM_PAL(4), .TRANSPARENT_IDX(0), .FLASH_FRAMES(8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, waits for the edge, samples 1ns later and returns to idle.
    task automatic applyStimulus(input logic we, input logic [1:0] wp, input logic [2:0] wi,
                                 input logic [23:0] wd, input logic pv, input logic [1:0] pp,
                                 input logic [2:0] pi, input logic fs, input logic fr,
                                 input logic [1:0] fp);
        bus.wr_en = we;        bus.wr_pal = wp;      bus.wr_idx = wi;  bus.wr_rgb = wd;
        bus.pix_valid_in = pv; bus.pix_pal = pp;     bus.pix_idx = pi;
        bus.frame_start = fs;  bus.flash_req = fr;   bus.flash_pal = fp;
        @(posedge Clk);
        #1;
        bus.wr_en = 1'b0;        bus.wr_pal = '0;      bus.wr_idx = '0;  bus.wr_rgb = '0;
        bus.pix_valid_in = 1'b0; bus.pix_pal = '0;     bus.pix_idx = '0;
        bus.frame_start = 1'b0;  bus.flash_req = 1'b0; bus.flash_pal = '0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writeEntry(input logic [1:0] pal, input logic [2:0] idx, input logic [23:0] rgb);
        applyStimulus(1, pal, idx, rgb, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookupEntry(input logic [1:0] pal, input logic [2:0] idx);
        applyStimulus(0, 0, 0, 0, 1, pal, idx, 0, 0, 0);
        idleCycles(1);
    endtask

    task automatic flashRequest(input logic [1:0] pal);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, pal);
    endtask

    task automatic framePulses(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    function automatic logic [31:0] rgbNow();
        return {8'h00, bus.Red, bus.Green, bus.Blue};
    endfunction

    initial begin
        int n;
        compared   = 0;
        mismatched = 0;
        Reset = 1'b1;
        bus.wr_en = 1'b0;        bus.wr_pal = '0;      bus.wr_idx = '0;  bus.wr_rgb = '0;
        bus.pix_valid_in = 1'b0; bus.pix_pal = '0;     bus.pix_idx = '0;
        bus.frame_start = 1'b0;  bus.flash_req = 1'b0; bus.flash_pal = '0;

        @(posedge Clk);
        #1;
        checkOutput("rst_busy",   32'(bus.init_busy), 32'd1);
        checkOutput("rst_rgb",    rgbNow(), 32'h0);
        checkOutput("rst_valid",  32'(bus.pix_valid_out), 32'd0);
        checkOutput("rst_transp", 32'(bus.transparent_out), 32'd0);
        checkOutput("rst_flash",  32'(bus.flash_active), 32'd0);
        Reset = 1'b0;

        n = 0;
        while (bus.init_busy && n < 100) begin
            idleCycles(1);
            n++;
        end
        checkOutput("init_len", 32'(n), 32'd32);

        applyStimulus(0, 0, 0, 0, 1, 2'd3, 3'd2, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 3'd0, 0, 0, 0);
        checkOutput("clr_valid",  32'(bus.pix_valid_out), 32'd1);
        checkOutput("clr_rgb",    rgbNow(), 32'h0);
        checkOutput("clr_transp", 32'(bus.transparent_out), 32'd0);
        idleCycles(1);
        checkOutput("idx0_valid",  32'(bus.pix_valid_out), 32'd1);
        checkOutput("idx0_transp", 32'(bus.transparent_out), 32'd1);
        checkOutput("idx0_rgb",    rgbNow(), 32'h0);

        writeEntry(2'd2, 3'd5, 24'h9B3110);
        applyStimulus(0, 0, 0, 0, 1, 2'd2, 3'd5, 0, 0, 0);
        checkOutput("lat_t1_valid", 32'(bus.pix_valid_out), 32'd0);
        idleCycles(1);
        checkOutput("lat_t2_valid",  32'(bus.pix_valid_out), 32'd1);
        checkOutput("lat_t2_rgb",    rgbNow(), 32'h9B3110);
        checkOutput("lat_t2_transp", 32'(bus.transparent_out), 32'd0);
        idleCycles(1);
        checkOutput("hold_valid", 32'(bus.pix_valid_out), 32'd0);
        checkOutput("hold_rgb",   rgbNow(), 32'h9B3110);

        writeEntry(2'd0, 3'd1, 24'h112233);
        writeEntry(2'd1, 3'd1, 24'h445566);
        writeEntry(2'd2, 3'd1, 24'h778899);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 3'd1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2'd1, 3'd1, 0, 0, 0);
        checkOutput("b2b_0", rgbNow(), 32'h112233);
        applyStimulus(0, 0, 0, 0, 1, 2'd2, 3'd1, 0, 0, 0);
        checkOutput("b2b_1", rgbNow(), 32'h445566);
        idleCycles(1);
        checkOutput("b2b_2",     rgbNow(), 32'h778899);
        checkOutput("b2b_2_vld", 32'(bus.pix_valid_out), 32'd1);
        idleCycles(1);
        checkOutput("b2b_end_vld", 32'(bus.pix_valid_out), 32'd0);

        writeEntry(2'd1, 3'd3, 24'h242424);
        applyStimulus(1, 2'd1, 3'd3, 24'hD4D4D7, 1, 2'd1, 3'd3, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2'd1, 3'd3, 0, 0, 0);
        checkOutput("coll_old", rgbNow(), 32'h242424);
        idleCycles(1);
        checkOutput("coll_new", rgbNow(), 32'hD4D4D7);

        writeEntry(2'd1, 3'd4, 24'h123456);
        writeEntry(2'd0, 3'd4, 24'hABCDEF);
        writeEntry(2'd1, 3'd0, 24'h010203);
        flashRequest(2'd1);
        checkOutput("fl_active", 32'(bus.flash_active), 32'd1);
        lookupEntry(2'd1, 3'd4);
        checkOutput("fl_white", rgbNow(), 32'hFFFFFF);
        lookupEntry(2'd0, 3'd4);
        checkOutput("fl_other_pal", rgbNow(), 32'hABCDEF);
        lookupEntry(2'd1, 3'd0);
        checkOutput("fl_transp",     32'(bus.transparent_out), 32'd1);
        checkOutput("fl_transp_rgb", rgbNow(), 32'h010203);
        framePulses(7);
        checkOutput("fl_after7", 32'(bus.flash_active), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 2'd1, 3'd4, 1, 0, 0);
        idleCycles(1);
        checkOutput("fl_8th_white", rgbNow(), 32'hFFFFFF);
        checkOutput("fl_8th_off",   32'(bus.flash_active), 32'd0);
        lookupEntry(2'd1, 3'd4);
        checkOutput("fl_ended_rgb", rgbNow(), 32'h123456);

        flashRequest(2'd1);
        framePulses(3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'd1);
        framePulses(7);
        checkOutput("restart_7", 32'(bus.flash_active), 32'd1);
        framePulses(1);
        checkOutput("restart_8", 32'(bus.flash_active), 32'd0);

        flashRequest(2'd1);
        flashRequest(2'd2);
        lookupEntry(2'd1, 3'd4);
        checkOutput("repl_old_pal", rgbNow(), 32'h123456);
        lookupEntry(2'd2, 3'd5);
        checkOutput("repl_new_pal", rgbNow(), 32'hFFFFFF);
        flashRequest(2'd3);

        Reset = 1'b1;
        idleCycles(1);
        checkOutput("rst2_flash", 32'(bus.flash_active), 32'd0);
        checkOutput("rst2_busy",  32'(bus.init_busy), 32'd1);
        Reset = 1'b0;
        lookupEntry(2'd2, 3'd5);
        checkOutput("init_lk_valid",  32'(bus.pix_valid_out), 32'd1);
        checkOutput("init_lk_rgb",    rgbNow(), 32'h0);
        checkOutput("init_lk_transp", 32'(bus.transparent_out), 32'd1);
        idleCycles(8);
        Reset = 1'b1;
        idleCycles(1);
        Reset = 1'b0;
        n = 0;
        while (bus.init_busy && n < 100) begin
            if (n == 3)      flashRequest(2'd0);
            else if (n == 5) writeEntry(2'd2, 3'd5, 24'h777777);
            else             idleCycles(1);
            n++;
        end
        checkOutput("resweep_len",   32'(n), 32'd32);
        checkOutput("init_flash_ok", 32'(bus.flash_active), 32'd1);
        lookupEntry(2'd2, 3'd5);
        checkOutput("resweep_wr_ignored", rgbNow(), 32'h0);
        checkOutput("resweep_transp",     32'(bus.transparent_out), 32'd0);
        lookupEntry(2'd1, 3'd3);
        checkOutput("resweep_cleared", rgbNow(), 32'h0);
        lookupEntry(2'd0, 3'd4);
        checkOutput("resweep_flash", rgbNow(), 32'hFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
